timing_ring: RTL and testbench
==============================

Name: timing_ring

Overview:
- 16-phase one-hot timing generator. It is the Mano control unit's sequence counter held in decoded form.
- Drives timing signals T0..T15 to the control logic. The same vector feeds the 16-to-4 encoder, which recovers the SC value for display and debug.
- Supports increment, clear and direct load, plus the start/stop (S) flip-flop that gates stepping.

Parameters:
- PHASES, 16, number of timing phases (one-hot width). Must be a power of two, at least 2.
- IDX_W, 4, width of the load index; equals log2(PHASES).
- RESET_RUN, 1, value of the running flag after reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sc_clr  input  1  clear request: the next phase is T0.
- sc_load  input  1  load request: the next phase is T[sc_value].
- sc_value  input  IDX_W  phase index used by sc_load.
- start  input  1  set the S flip-flop.
- stop  input  1  clear the S flip-flop (HLT).
- timing  output  PHASES  one-hot phase vector; bit i is Ti.
- running  output  1  S flip-flop state.
- wrap  output  1  one-cycle pulse after the phase steps T15 to T0.

Behaviour:
- Interface: one clock (clk); reset (reset_n) is asynchronous and active-low.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (reset_n low, asynchronous):
  - timing = 16'h0001 (T0)
  - running = RESET_RUN
  - wrap = 0
  - Deasserting reset mid-sequence always restarts from T0.
- Phase update at each rising edge, highest priority first:
  1. sc_clr=1: timing <= T0.
  2. sc_load=1: timing <= one-hot(sc_value). sc_value is always in range when PHASES = 2^IDX_W.
  3. running=1 (value before the edge): timing <= rotate-left by 1, so T15 goes to T0.
  4. Otherwise: hold.
- sc_clr and sc_load act regardless of running. A halted machine can still be cleared or loaded.
- Running flag:
  - stop=1: running <= 0.
  - else start=1: running <= 1.
  - else hold.
  - stop wins when start and stop are asserted together.
  - Stepping uses the pre-edge running value. A stop sampled at edge k still allows the step at edge k; no step occurs from edge k+1 on.
  - A start sampled at edge k causes the first step at edge k+1.
- wrap:
  - Set to 1 for exactly one cycle when the edge performed a rotate step (case 3) from timing[PHASES-1].
  - Cleared otherwise, including clear or load from T15, and a halted hold at T15.
- Invariant: timing has exactly one bit set in every cycle after reset. The downstream encoder relies on this invariant.
- No internal binary counter is exposed. Any internal implementation is allowed if the port behaviour above holds.

Test Plan:
- Reset then release with RESET_RUN=1, no other inputs:
  - timing = 0001 at release.
  - 0002, 0004, ... 8000 over the next 15 edges.
  - The next edge gives 0001 with wrap=1 for one cycle; wrap=0 otherwise.
- From T5, assert stop for one cycle:
  - timing goes to T6 at that edge, running=0.
  - timing stays 0040 for 10 cycles.
  - Pulse start: one more cycle holding, then T7.
- From T9 running, sc_clr=1 and sc_load=1 with sc_value=12 together: timing = 0001 (clear wins), wrap=0.
- Halted at T3, sc_load=1, sc_value=15: timing = 8000. Then start: T15 to T0 with wrap=1.
- start and stop both high while halted at T2: running stays 0, timing holds 0004.
- Assert reset_n low asynchronously mid-cycle at T11 while running: timing = 0001 immediately, before the next clk edge; running = RESET_RUN; wrap=0.
- At every sampled cycle, a checker asserts that timing is one-hot.

Source files
------------

// File: rtl/timing_ring.sv
// One-hot phase generator (decoded sequence counter) with start/stop run flag.
// Steps T0..T(PHASES-1) cyclically while running; clear and load override stepping.
module timing_ring #(
    parameter int PHASES    = 16,
    parameter int IDX_W     = 4,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sc_clr,
    input  logic              sc_load,
    input  logic [IDX_W-1:0]  sc_value,
    input  logic              start,
    input  logic              stop,
    output logic [PHASES-1:0] timing,
    output logic              running,
    output logic              wrap
);

    logic [PHASES-1:0] timing_next;
    logic              running_next;
    logic              wrap_next;

    always_comb begin
        timing_next = timing;
        wrap_next   = 1'b0;
        if (sc_clr) begin
            timing_next = PHASES'(1);
        end else if (sc_load) begin
            timing_next = PHASES'(1) << sc_value;
        end else if (running) begin
            // wrap marks only a genuine rotate out of the last phase
            timing_next = {timing[PHASES-2:0], timing[PHASES-1]};
            wrap_next   = timing[PHASES-1];
        end
    end

    always_comb begin
        running_next = running;
        if (stop) begin
            running_next = 1'b0;
        end else if (start) begin
            running_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timing  <= PHASES'(1);
            running <= RESET_RUN;
            wrap    <= 1'b0;
        end else begin
            timing  <= timing_next;
            running <= running_next;
            wrap    <= wrap_next;
        end
    end

endmodule

// File: tb/tb_timing_ring.sv
// Directed bench for timing_ring: stepping, wrap, stop/start, clear/load priority, async reset.
module tb_timing_ring;

    logic        clk;
    logic        reset_n;
    logic        sc_clr;
    logic        sc_load;
    logic [3:0]  sc_value;
    logic        start;
    logic        stop;
    logic [15:0] timing;
    logic        running;
    logic        wrap;

    int n_assert = 0;
    int n_fail   = 0;

    timing_ring #(.PHASES(16), .IDX_W(4), .RESET_RUN(1'b1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sc_clr   (sc_clr),
        .sc_load  (sc_load),
        .sc_value (sc_value),
        .start    (start),
        .stop     (stop),
        .timing   (timing),
        .running  (running),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            n_assert++;
            assert ($onehot(timing)) else begin
                n_fail++;
                $error("FAIL onehot: observed %h expected one bit set", timing);
            end
        end
    end

    initial begin
        logic [15:0] exp;
        reset_n  = 1'b0;
        sc_clr   = 1'b0;
        sc_load  = 1'b0;
        sc_value = 4'd0;
        start    = 1'b0;
        stop     = 1'b0;

        repeat (2) step();
        check("rst_timing", timing, 16'h0001);
        check("rst_running", {15'd0, running}, 16'd1);
        check("rst_wrap", {15'd0, wrap}, 16'd0);
        reset_n = 1'b1;
        check("release_timing", timing, 16'h0001);

        for (int i = 1; i < 16; i++) begin
            step();
            exp = 16'h0001 << i;
            check("ring_step", timing, exp);
            check("ring_wrap_low", {15'd0, wrap}, 16'd0);
        end
        step();
        check("wrap_timing", timing, 16'h0001);
        check("wrap_pulse", {15'd0, wrap}, 16'd1);
        step();
        check("after_wrap_timing", timing, 16'h0002);
        check("after_wrap_pulse", {15'd0, wrap}, 16'd0);

        repeat (4) step();
        check("at_t5", timing, 16'h0020);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_step_t6", timing, 16'h0040);
        check("stop_running", {15'd0, running}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_hold", timing, 16'h0040);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_hold", timing, 16'h0040);
        check("start_running", {15'd0, running}, 16'd1);
        step();
        check("start_t7", timing, 16'h0080);

        repeat (2) step();
        check("at_t9", timing, 16'h0200);
        sc_clr   = 1'b1;
        sc_load  = 1'b1;
        sc_value = 4'd12;
        step();
        sc_clr  = 1'b0;
        sc_load = 1'b0;
        check("clr_wins", timing, 16'h0001);
        check("clr_wrap", {15'd0, wrap}, 16'd0);

        step();
        check("at_t1", timing, 16'h0002);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("halt_t2", timing, 16'h0004);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("both_timing", timing, 16'h0004);
        check("both_running", {15'd0, running}, 16'd0);

        sc_load  = 1'b1;
        sc_value = 4'd3;
        step();
        check("load_t3_halted", timing, 16'h0008);
        sc_value = 4'd15;
        step();
        sc_load = 1'b0;
        check("load_t15", timing, 16'h8000);
        check("load_t15_wrap", {15'd0, wrap}, 16'd0);
        step();
        check("halt_t15_hold", timing, 16'h8000);
        check("halt_t15_wrap", {15'd0, wrap}, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_t15_hold", timing, 16'h8000);
        step();
        check("resume_wrap_timing", timing, 16'h0001);
        check("resume_wrap_pulse", {15'd0, wrap}, 16'd1);
        step();
        check("resume_t1", timing, 16'h0002);
        check("resume_wrap_clear", {15'd0, wrap}, 16'd0);

        sc_load  = 1'b1;
        sc_value = 4'd15;
        step();
        sc_load = 1'b0;
        check("run_load_t15", timing, 16'h8000);
        sc_load  = 1'b1;
        sc_value = 4'd9;
        step();
        sc_load = 1'b0;
        check("load_from_t15", timing, 16'h0200);
        check("load_from_t15_wrap", {15'd0, wrap}, 16'd0);

        repeat (2) step();
        check("at_t11", timing, 16'h0800);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_timing", timing, 16'h0001);
        check("async_running", {15'd0, running}, 16'd1);
        check("async_wrap", {15'd0, wrap}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post_reset_step", timing, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
